// File: rtl/phase_run_timer_if.sv
// Bus between the machine-level controller and the phase run timer.
// The controller (master) supplies state, programmed times and the skip
// request; the timer (slave) returns the remaining times, phase status and
// the begin/finish countdowns.
interface phase_run_timer_if #(
    parameter int NUM_PHASES = 8,
    parameter int PHASE_W    = 4,
    parameter int TIMER_W    = 3,
    parameter int PIDX_W     = 3
);
    logic [2:0]                    state;
    logic [NUM_PHASES*PHASE_W-1:0] data;
    logic                          skip_phase;
    logic [NUM_PHASES*PHASE_W-1:0] msg;
    logic [PIDX_W-1:0]             phase_idx;
    logic                          phase_done;
    logic                          had_finish;
    logic [TIMER_W-1:0]            init_time;
    logic [TIMER_W-1:0]            finish_time;
    logic                          tick;

    modport master (
        output state, data, skip_phase,
        input  msg, phase_idx, phase_done, had_finish, init_time, finish_time, tick
    );

    modport slave (
        input  state, data, skip_phase,
        output msg, phase_idx, phase_done, had_finish, init_time, finish_time, tick
    );
endinterface

// File: rtl/phase_run_timer.sv
// Multi-phase run countdown. Holds the remaining time per phase and drains
// it one unit per tick while running, highest-index phase first. Also runs
// the begin/finish countdowns, flags phase completion and end of run, and
// honours a skip command that clears the active phase.
module phase_run_timer #(
    parameter int NUM_PHASES  = 8,
    parameter int PHASE_W     = 4,
    parameter int TICK_DIV    = 10,
    parameter int TIMER_W     = 3,
    parameter int INIT_TIME   = 5,
    parameter int FINISH_TIME = 5,
    parameter int PIDX_W      = 3
) (
    input  logic             clk,
    input  logic             reset,
    phase_run_timer_if.slave bus
);
    localparam int MSG_W = NUM_PHASES * PHASE_W;
    localparam int CNT_W = $clog2(TICK_DIV);

    localparam logic [CNT_W-1:0]   CNT_LAST      = CNT_W'(TICK_DIV - 1);
    localparam logic [TIMER_W-1:0] INIT_RELOAD   = TIMER_W'(INIT_TIME);
    localparam logic [TIMER_W-1:0] FINISH_RELOAD = TIMER_W'(FINISH_TIME);

    localparam logic [2:0] ST_BEGIN  = 3'd1;
    localparam logic [2:0] ST_RUN    = 3'd3;
    localparam logic [2:0] ST_ERROR  = 3'd4;
    localparam logic [2:0] ST_PAUSE  = 3'd5;
    localparam logic [2:0] ST_FINISH = 3'd6;

    logic [CNT_W-1:0]   tick_cnt;
    logic               tick_r;
    logic [MSG_W-1:0]   msg_r;
    logic [MSG_W-1:0]   run_msg;
    logic               run_done;
    logic               msg_nz;
    logic               phase_done_r;
    logic               had_finish_r;
    logic [TIMER_W-1:0] init_r;
    logic [TIMER_W-1:0] finish_r;
    logic [PHASE_W-1:0] act_field;
    int                 act_i;

    // Countdown step that holds at zero instead of wrapping.
    function automatic logic [TIMER_W-1:0] sat_dec(input logic [TIMER_W-1:0] v);
        return (v == '0) ? v : v - TIMER_W'(1);
    endfunction

    // Free-running tick divider; tick is registered and marks the wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
            tick_r   <= 1'b0;
        end else if (tick_cnt == CNT_LAST) begin
            tick_cnt <= '0;
            tick_r   <= 1'b1;
        end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
            tick_r   <= 1'b0;
        end
    end

    // Find the active (highest non-zero) phase and form the next run vector;
    // a skip takes priority over a same-cycle tick decrement.
    always_comb begin
        act_i     = 0;
        act_field = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            if (msg_r[i*PHASE_W +: PHASE_W] != '0) begin
                act_i     = i;
                act_field = msg_r[i*PHASE_W +: PHASE_W];
            end
        end
        msg_nz   = (msg_r != '0);
        run_msg  = msg_r;
        run_done = 1'b0;
        if (msg_nz) begin
            for (int i = 0; i < NUM_PHASES; i++) begin
                if (i == act_i) begin
                    if (bus.skip_phase) begin
                        run_msg[i*PHASE_W +: PHASE_W] = '0;
                        run_done = 1'b1;
                    end else if (tick_r) begin
                        run_msg[i*PHASE_W +: PHASE_W] = act_field - PHASE_W'(1);
                        run_done = (act_field == PHASE_W'(1));
                    end
                end
            end
        end
    end

    // Per-state update of remaining times, countdown timers and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            msg_r        <= '0;
            phase_done_r <= 1'b0;
            had_finish_r <= 1'b0;
            init_r       <= INIT_RELOAD;
            finish_r     <= FINISH_RELOAD;
        end else begin
            phase_done_r <= 1'b0;
            had_finish_r <= 1'b0;
            init_r       <= INIT_RELOAD;
            finish_r     <= FINISH_RELOAD;
            case (bus.state)
                ST_RUN: begin
                    msg_r        <= run_msg;
                    phase_done_r <= run_done;
                    had_finish_r <= had_finish_r | (tick_r & ~msg_nz);
                end
                ST_BEGIN: begin
                    msg_r  <= bus.data;
                    init_r <= tick_r ? sat_dec(init_r) : init_r;
                end
                ST_FINISH: begin
                    msg_r    <= bus.data;
                    finish_r <= tick_r ? sat_dec(finish_r) : finish_r;
                end
                ST_PAUSE, ST_ERROR: begin
                    msg_r <= msg_r;
                end
                default: begin
                    msg_r <= bus.data;
                end
            endcase
        end
    end

    assign bus.msg         = msg_r;
    assign bus.phase_idx   = PIDX_W'(act_i);
    assign bus.phase_done  = phase_done_r;
    assign bus.had_finish  = had_finish_r;
    assign bus.init_time   = init_r;
    assign bus.finish_time = finish_r;
    assign bus.tick        = tick_r;
endmodule
